mat4_mul_seq: RTL

- Sequential 4x4 signed fixed-point matrix multiplier, C = A x B. It is the forward-direction companion to the matrix-inverse path.
- Used to rebuild a matrix from its inverse, and to check inverse results: the product of a matrix and its inverse is the identity.
- One multiply-accumulate per clock. Operands are captured at start, and the full result is presented at once at done.

---
 rtl/mat_pkg.sv | 25 ++
 rtl/q_round_sat.sv | 35 +++
 rtl/mat4_mul_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mat_pkg.sv
// Shared definitions for the fixed-point 4x4 matrix blocks:
// element format defaults, the sequencer state type, Q16.16 constants
// and the row-major element index helper.
package mat_pkg;

    localparam int W_DEF    = 32;
    localparam int FRAC_DEF = 16;
    localparam int N        = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] ONE     = 32'h0001_0000;
    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

    // Row-major position of element (r,c) inside a packed 16-element matrix.
    function automatic int idx(input int r, input int c);
        return r * N + c;
    endfunction

endpackage

// File: rtl/q_round_sat.sv
// Converts a wide signed accumulator back to one W-bit fixed-point element:
// round half toward +infinity, then clamp to the signed W-bit range.
module q_round_sat #(
    parameter int W         = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic signed [2*W+1:0] acc,
    output logic        [W-1:0]   q,
    output logic                  sat
);

    localparam int AW = 2 * W + 2;
    localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC_BITS - 1);
    localparam logic signed [AW-1:0] MAXV = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [AW-1:0] biased;
    logic signed [AW-1:0] shifted;

    // Bias by half an LSB, drop the fraction bits, then clamp out-of-range values.
    always_comb begin
        biased  = acc + HALF;
        shifted = biased >>> FRAC_BITS;
        sat     = 1'b0;
        q       = shifted[W-1:0];
        if (shifted > MAXV) begin
            q   = MAXV[W-1:0];
            sat = 1'b1;
        end else if (shifted < MINV) begin
            q   = MINV[W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/mat4_mul_seq.sv
// Sequential 4x4 signed fixed-point matrix multiplier, C = A x B.
// One multiply-accumulate per clock; all 16 result elements appear together
// on c_out when done pulses.
module mat4_mul_seq
    import mat_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_DEF,
    parameter int W         = W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [16*W-1:0]   a_in,
    input  logic [16*W-1:0]   b_in,
    output logic              busy,
    output logic              done,
    output logic [16*W-1:0]   c_out,
    output logic              ovf
);

    localparam int AW = 2 * W + 2;

    state_t state;
    state_t state_next;

    logic [1:0]            i;
    logic [1:0]            j;
    logic [1:0]            k;
    logic [16*W-1:0]       a_reg;
    logic [16*W-1:0]       b_reg;
    logic [16*W-1:0]       result_buf;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  acc_sum;
    logic signed [W-1:0]   a_el;
    logic signed [W-1:0]   b_el;
    logic signed [2*W-1:0] prod;
    logic [W-1:0]          elem;
    logic                  elem_sat;
    logic                  acc_done;
    logic                  last_mac;

    // Select A[i][k] and B[k][j], form the full-width product and the running sum.
    always_comb begin
        a_el     = a_reg[W*idx(int'(i), int'(k)) +: W];
        b_el     = b_reg[W*idx(int'(k), int'(j)) +: W];
        prod     = a_el * b_el;
        acc_sum  = acc + AW'(prod);
        acc_done = (k == 2'd3);
        last_mac = acc_done && (j == 2'd3) && (i == 2'd3);
    end

    q_round_sat #(
        .W         (W),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
        .acc (acc_sum),
        .q   (elem),
        .sat (elem_sat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one accept, 64 MAC cycles, one DONE cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_mac) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded straight from the state.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Datapath: operand capture, accumulation, result buffering and the output
    // matrix. c_out is loaded on the final MAC edge (buffer plus the last element)
    // so it is already valid throughout the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            result_buf <= '0;
            acc        <= '0;
            i          <= '0;
            j          <= '0;
            k          <= '0;
            c_out      <= '0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a_in;
                        b_reg <= b_in;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                    end
                end
                RUN: begin
                    k <= k + 2'd1;
                    if (acc_done) begin
                        result_buf[W*idx(int'(i), int'(j)) +: W] <= elem;
                        acc <= '0;
                        j   <= j + 2'd1;
                        if (j == 2'd3) begin
                            i <= i + 2'd1;
                        end
                        if (elem_sat) begin
                            ovf <= 1'b1;
                        end
                        if (last_mac) begin
                            c_out            <= result_buf;
                            c_out[W*15 +: W] <= elem;
                        end
                    end else begin
                        acc <= acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
